// File: rtl/vga_grad_filter.sv
// Streaming per-channel gradient filter on the VGA path, 2-cycle latency on all signals.
// Define VGA_GRAD_FILTER_THRESH_EN to binarise filtered channels against thresh.
module vga_grad_filter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int CW     = 8
) (
    input  logic          VGA_CLK,
    input  logic          reset_n,
    input  logic [CW-1:0] iVGA_R,
    input  logic [CW-1:0] iVGA_G,
    input  logic [CW-1:0] iVGA_B,
    input  logic          iVGA_HS,
    input  logic          iVGA_VS,
    input  logic          iVGA_SYNC_N,
    input  logic          iVGA_BLANK_N,
    input  logic [1:0]    mode,
    input  logic [2:0]    chan_en,
    input  logic [CW-1:0] thresh,
    output logic [CW-1:0] oVGA_R,
    output logic [CW-1:0] oVGA_G,
    output logic [CW-1:0] oVGA_B,
    output logic          oVGA_HS,
    output logic          oVGA_VS,
    output logic          oVGA_SYNC_N,
    output logic          oVGA_BLANK_N,
    output logic [7:0]    frame_cnt
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int PW = 3 * CW;
    localparam logic [CW-1:0] MAXV = '1;

`ifdef VGA_GRAD_FILTER_THRESH_EN
    localparam bit THRESH_EN = 1'b1;
    logic [CW-1:0] thresh_w;
    assign thresh_w = thresh;
`else
    localparam bit THRESH_EN = 1'b0;
    logic [CW-1:0] thresh_w;
    logic          unused_thresh;
    assign thresh_w      = '0;
    assign unused_thresh = ^thresh;
`endif

    function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [CW-1:0] grad(input logic [1:0] m, input logic [CW-1:0] p,
                                           input logic [CW-1:0] l, input logic [CW-1:0] u);
        logic [CW-1:0] h;
        logic [CW-1:0] v;
        logic [CW:0]   s;
        logic [CW-1:0] r;
        h = abs_diff(p, l);
        v = abs_diff(p, u);
        s = {1'b0, h} + {1'b0, v};
        case (m)
            2'd1:    r = h;
            2'd2:    r = v;
            2'd3:    r = s[CW] ? MAXV : s[CW-1:0];
            default: r = p;
        endcase
        return r;
    endfunction

    logic [PW-1:0] pix_in;
    assign pix_in = {iVGA_R, iVGA_G, iVGA_B};

    // Front-end state: counters, edge detectors, latched configuration.
    logic [XW-1:0] x_q, x_d;
    logic          x_full_q, x_full_d;
    logic [YW-1:0] y_q, y_d;
    logic          row_valid_q, row_valid_d;
    logic          blank_prev_q, blank_prev_d;
    logic          vs_prev_q, vs_prev_d;
    logic [7:0]    frame_q, frame_d;
    logic [1:0]    mode_q, mode_d;
    logic [2:0]    chan_en_q, chan_en_d;

    // Stage 1 and stage 2 pipeline registers.
    logic [PW-1:0] pix1_q, pix1_d;
    logic [PW-1:0] left1_q, left1_d;
    logic [PW-1:0] up1_q, up1_d;
    logic          rv1_q, rv1_d;
    logic          hs1_q, hs1_d, vs1_q, vs1_d, sync1_q, sync1_d, blank1_q, blank1_d;
    logic [PW-1:0] rgb2_q, rgb2_d;
    logic          hs2_q, hs2_d, vs2_q, vs2_d, sync2_q, sync2_d, blank2_q, blank2_d;

    logic [PW-1:0] line_mem [WIDTH];
    logic          wr_en;
    logic          blank_fall;
    logic [CW-1:0] grad_c [3];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a value held and no latch is inferred.
        x_d          = x_q;
        x_full_d     = x_full_q;
        y_d          = y_q;
        row_valid_d  = row_valid_q;
        blank_fall   = blank_prev_q & ~iVGA_BLANK_N;
        blank_prev_d = iVGA_BLANK_N;
        vs_prev_d    = iVGA_VS;
        frame_d      = (~vs_prev_q & iVGA_VS) ? frame_q + 8'd1 : frame_q;
        mode_d       = iVGA_VS ? mode_q : mode;
        chan_en_d    = iVGA_VS ? chan_en_q : chan_en;
        wr_en        = iVGA_BLANK_N & ~x_full_q;

        // x holds at WIDTH-1 once the last column is written; later pixels are dropped.
        if (!iVGA_BLANK_N) begin
            x_d      = '0;
            x_full_d = 1'b0;
        end else if (x_q == XW'(WIDTH - 1)) begin
            x_full_d = 1'b1;
        end else begin
            x_d = x_q + XW'(1);
        end

        if (!iVGA_VS) begin
            y_d         = '0;
            row_valid_d = 1'b0;
        end else if (blank_fall) begin
            row_valid_d = 1'b1;
            if (y_q != YW'(HEIGHT - 1)) y_d = y_q + YW'(1);
        end

        pix1_d   = pix_in;
        left1_d  = (x_q == '0) ? pix_in : pix1_q;
        up1_d    = line_mem[x_q];
        rv1_d    = row_valid_q;
        hs1_d    = iVGA_HS;
        vs1_d    = iVGA_VS;
        sync1_d  = iVGA_SYNC_N;
        blank1_d = iVGA_BLANK_N;
    end

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            grad_c[c] = grad(mode_q, pix1_q[c*CW +: CW], left1_q[c*CW +: CW],
                             rv1_q ? up1_q[c*CW +: CW] : pix1_q[c*CW +: CW]);
        end
    end

    always_comb begin
        rgb2_d = pix1_q;
        for (int c = 0; c < 3; c++) begin
            if (chan_en_q[c]) begin
                if (THRESH_EN && mode_q != 2'd0)
                    rgb2_d[c*CW +: CW] = (grad_c[c] >= thresh_w) ? MAXV : '0;
                else
                    rgb2_d[c*CW +: CW] = grad_c[c];
            end
        end
        if (!blank1_q) rgb2_d = '0;
        hs2_d    = hs1_q;
        vs2_d    = vs1_q;
        sync2_d  = sync1_q;
        blank2_d = blank1_q;
    end

    // NOTE: the line buffer is not reset; stale contents are masked by row_valid.
    always_ff @(posedge VGA_CLK) begin
        if (wr_en) line_mem[x_q] <= pix_in;
        up1_q <= up1_d;
    end

    always_ff @(posedge VGA_CLK) begin
        // NOTE: reset is synchronous, so it is tested inside the edge-triggered block and all state uses <=.
        if (!reset_n) begin
            x_q          <= '0;
            x_full_q     <= 1'b0;
            y_q          <= '0;
            row_valid_q  <= 1'b0;
            blank_prev_q <= 1'b0;
            vs_prev_q    <= 1'b1;
            frame_q      <= '0;
            mode_q       <= '0;
            chan_en_q    <= '0;
            pix1_q       <= '0;
            left1_q      <= '0;
            rv1_q        <= 1'b0;
            hs1_q        <= 1'b1;
            vs1_q        <= 1'b1;
            sync1_q      <= 1'b0;
            blank1_q     <= 1'b0;
            rgb2_q       <= '0;
            hs2_q        <= 1'b1;
            vs2_q        <= 1'b1;
            sync2_q      <= 1'b0;
            blank2_q     <= 1'b0;
        end else begin
            x_q          <= x_d;
            x_full_q     <= x_full_d;
            y_q          <= y_d;
            row_valid_q  <= row_valid_d;
            blank_prev_q <= blank_prev_d;
            vs_prev_q    <= vs_prev_d;
            frame_q      <= frame_d;
            mode_q       <= mode_d;
            chan_en_q    <= chan_en_d;
            pix1_q       <= pix1_d;
            left1_q      <= left1_d;
            rv1_q        <= rv1_d;
            hs1_q        <= hs1_d;
            vs1_q        <= vs1_d;
            sync1_q      <= sync1_d;
            blank1_q     <= blank1_d;
            rgb2_q       <= rgb2_d;
            hs2_q        <= hs2_d;
            vs2_q        <= vs2_d;
            sync2_q      <= sync2_d;
            blank2_q     <= blank2_d;
        end
    end

    assign oVGA_R       = rgb2_q[2*CW +: CW];
    assign oVGA_G       = rgb2_q[CW +: CW];
    assign oVGA_B       = rgb2_q[0 +: CW];
    assign oVGA_HS      = hs2_q;
    assign oVGA_VS      = vs2_q;
    assign oVGA_SYNC_N  = sync2_q;
    assign oVGA_BLANK_N = blank2_q;
    assign frame_cnt    = frame_q;

endmodule

// File: tb/tb_vga_grad_filter.sv
// Self-checking bench for vga_grad_filter: table-driven frame checks plus a per-cycle reference model.
module tb_vga_grad_filter;
    localparam int W  = 10;
    localparam int H  = 10;
    localparam int HB = 6;
`ifdef VGA_GRAD_FILTER_THRESH_EN
    localparam bit TH = 1'b1;
`else
    localparam bit TH = 1'b0;
`endif

    logic       VGA_CLK = 1'b0;
    logic       reset_n;
    logic [7:0] iR, iG, iB, oR, oG, oB, thresh, frame_cnt;
    logic       iHS, iVS, iSYNC, iBLANK, oHS, oVS, oSYNC, oBLANK;
    logic [1:0] mode;
    logic [2:0] chan_en;

    always #5 VGA_CLK = ~VGA_CLK;

    vga_grad_filter #(.WIDTH(W), .HEIGHT(H), .CW(8)) dut (
        .VGA_CLK(VGA_CLK), .reset_n(reset_n),
        .iVGA_R(iR), .iVGA_G(iG), .iVGA_B(iB),
        .iVGA_HS(iHS), .iVGA_VS(iVS), .iVGA_SYNC_N(iSYNC), .iVGA_BLANK_N(iBLANK),
        .mode(mode), .chan_en(chan_en), .thresh(thresh),
        .oVGA_R(oR), .oVGA_G(oG), .oVGA_B(oB),
        .oVGA_HS(oHS), .oVGA_VS(oVS), .oVGA_SYNC_N(oSYNC), .oVGA_BLANK_N(oBLANK),
        .frame_cnt(frame_cnt)
    );

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs, vs, sync_n, blank_n;
    } vid_t;
    localparam vid_t RST_VID = '{rgb: 24'h0, hs: 1'b1, vs: 1'b1, sync_n: 1'b0, blank_n: 1'b0};

    typedef struct {
        int          md, ch, img, thr, chg, x, y;
        logic [23:0] exp;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    vid_t        exp_q[$];
    vec_t        vt[$];

    // Reference-model state, expressed in terms of frame geometry.
    int          col;
    bit          rv, prev_blank, prev_vs;
    logic [7:0]  m_frames;
    logic [1:0]  m_mode;
    logic [2:0]  m_chan;
    logic [23:0] m_line [W];
    logic [23:0] m_last;

    logic [23:0] cap [H][W];
    int          ox = 0, oy = 0;
    bit          prev_oblank = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_chan(int p, int l, int u, int md, bit en, int thr);
        int h, v, r;
        h = (p > l) ? p - l : l - p;
        v = (p > u) ? p - u : u - p;
        if (!en || md == 0) return 8'(p);
        if (md == 1)      r = h;
        else if (md == 2) r = v;
        else              r = (h + v > 255) ? 255 : h + v;
        if (TH) r = (r >= thr) ? 255 : 0;
        return 8'(r);
    endfunction

    function automatic logic [23:0] pix(int img, int x, int y);
        case (img)
            0:       return {8'(x), 8'(y), 8'(x + y)};
            1:       return {((x + y) % 2 == 1) ? 8'd255 : 8'd0, 8'(7 * x), 8'(3 * y)};
            2:       return {8'(3 * x), 16'h0};
            default: return 24'($urandom);
        endcase
    endfunction

    task automatic step(input bit rst, input logic [23:0] px, input bit hs, input bit vs, input bit blank);
        vid_t        e, a;
        logic [23:0] up, left;
        reset_n      = rst;
        {iR, iG, iB} = px;
        iHS          = hs;
        iVS          = vs;
        iBLANK       = blank;
        iSYNC        = 1'($urandom_range(0, 1));
        if (!rst) begin
            exp_q.delete();
            exp_q.push_back(RST_VID);
            exp_q.push_back(RST_VID);
            col = 0; rv = 0; prev_blank = 0; prev_vs = 1;
            m_frames = 0; m_mode = 0; m_chan = 0;
        end else begin
            e.rgb = '0; e.hs = hs; e.vs = vs; e.sync_n = iSYNC; e.blank_n = blank;
            if (blank) begin
                up   = rv ? m_line[(col < W) ? col : W - 1] : px;
                left = (col == 0) ? px : m_last;
                for (int c = 0; c < 3; c++)
                    e.rgb[c*8 +: 8] = model_chan(px[c*8 +: 8], left[c*8 +: 8], up[c*8 +: 8],
                                                 m_mode, m_chan[c], thresh);
                if (col < W) m_line[col] = px;
                m_last = px;
                col++;
            end else begin
                col = 0;
            end
            exp_q.push_back(e);
            if (prev_blank && !blank) rv = 1;
            if (!vs) begin rv = 0; m_mode = mode; m_chan = chan_en; end
            if (!prev_vs && vs) m_frames++;
            prev_blank = blank;
            prev_vs    = vs;
        end

        @(posedge VGA_CLK);
        #1;
        a.rgb = {oR, oG, oB}; a.hs = oHS; a.vs = oVS; a.sync_n = oSYNC; a.blank_n = oBLANK;
        if (exp_q.size() == 0) check("pipe_empty", 64'd1, 64'd0);
        else begin
            e = exp_q.pop_front();
            check("pipe", 64'(a), 64'(e));
        end
        check("frame_cnt", 64'(frame_cnt), 64'(m_frames));
        if (!rst) begin
            check("rst_rgb", 64'({oR, oG, oB}), 64'd0);
            check("rst_hs_vs", 64'({oHS, oVS}), 64'd3);
            check("rst_sync_blank", 64'({oSYNC, oBLANK}), 64'd0);
        end

        if (!oVS) oy = 0;
        if (oBLANK) begin
            if (ox < W && oy < H) cap[oy][ox] = {oR, oG, oB};
            ox++;
        end else begin
            if (prev_oblank) oy++;
            ox = 0;
        end
        prev_oblank = oBLANK;
    endtask

    task automatic run_frame(input int img, input int len, input int chg_line, input int chg_mode,
                             input int rst_line);
        for (int i = 0; i < len + HB; i++) step(1'b1, '0, !(i >= 2 && i < 4), 1'b0, 1'b0);
        for (int i = 0; i < len + HB; i++) step(1'b1, '0, !(i >= 2 && i < 4), 1'b1, 1'b0);
        for (int y = 0; y < H; y++) begin
            if (y == chg_line) mode = 2'(chg_mode);
            for (int x = 0; x < len; x++) step(1'b1, pix(img, x, y), 1'b1, 1'b1, 1'b1);
            for (int j = 0; j < HB; j++)
                step(!(y == rst_line && j < 3), '0, !(j >= 2 && j < 4), 1'b1, 1'b0);
        end
        for (int i = 0; i < len + HB; i++) step(1'b1, '0, !(i >= 2 && i < 4), 1'b1, 1'b0);
    endtask

    task automatic add(input int md, input int ch, input int img, input int thr, input int chg,
                       input int x, input int y, input logic [23:0] raw, input logic [23:0] bin);
        vec_t v;
        v.md = md; v.ch = ch; v.img = img; v.thr = thr; v.chg = chg; v.x = x; v.y = y;
        v.exp = TH ? bin : raw;
        vt.push_back(v);
    endtask

    initial begin
        mode = 0; chan_en = 0; thresh = 0;
        foreach (m_line[i]) m_line[i] = '0;
        m_last = '0;

        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);

        //   md ch img thr chg  x  y  raw         binarised
        add(0, 7, 0, 1, -1, 3, 4, 24'h030407, 24'h030407);
        add(0, 7, 0, 1, -1, 9, 9, 24'h090912, 24'h090912);
        add(1, 7, 0, 1, -1, 0, 5, 24'h000000, 24'h000000);
        add(1, 7, 0, 1, -1, 4, 5, 24'h010001, 24'hFF00FF);
        add(2, 7, 0, 1, -1, 3, 0, 24'h000000, 24'h000000);
        add(2, 7, 0, 1, -1, 3, 6, 24'h000101, 24'h00FFFF);
        add(2, 7, 0, 1,  1, 3, 6, 24'h000101, 24'h00FFFF);
        add(2, 7, 0, 1,  1, 4, 8, 24'h000101, 24'h00FFFF);
        add(1, 7, 0, 1, -1, 4, 8, 24'h010001, 24'hFF00FF);
        add(3, 4, 1, 1, -1, 0, 0, 24'h000000, 24'h000000);
        add(3, 4, 1, 1, -1, 1, 0, 24'hFF0700, 24'hFF0700);
        add(3, 4, 1, 1, -1, 4, 5, 24'hFF1C0F, 24'hFF1C0F);
        add(3, 4, 1, 1, -1, 0, 1, 24'hFF0003, 24'hFF0003);
        add(3, 7, 1, 1, -1, 5, 5, 24'hFF0703, 24'hFFFFFF);
        add(3, 7, 0, 2, -1, 2, 3, 24'h010102, 24'h0000FF);
        add(1, 7, 2, 2, -1, 5, 3, 24'h030000, 24'hFF0000);
        add(1, 7, 2, 2, -1, 0, 3, 24'h000000, 24'h000000);

        for (int i = 0; i < vt.size(); i++) begin
            if (i == 0 || vt[i].md != vt[i-1].md || vt[i].ch != vt[i-1].ch || vt[i].img != vt[i-1].img ||
                vt[i].thr != vt[i-1].thr || vt[i].chg != vt[i-1].chg) begin
                mode    = 2'(vt[i].md);
                chan_en = 3'(vt[i].ch);
                thresh  = 8'(vt[i].thr);
                run_frame(vt[i].img, W, (vt[i].chg >= 0) ? 5 : -1, vt[i].chg, -1);
            end
            check($sformatf("vec%0d(x%0d,y%0d)", i, vt[i].x, vt[i].y),
                  64'(cap[vt[i].y][vt[i].x]), 64'(vt[i].exp));
        end

        // Reset in the blank before line 5, then a clean frame.
        mode = 2; chan_en = 7; thresh = 1;
        run_frame(0, W, -1, 0, 4);
        run_frame(0, W, -1, 0, -1);

        // Random images and configurations, including over-long lines.
        for (int k = 0; k < 6; k++) begin
            mode    = 2'($urandom);
            chan_en = 3'($urandom);
            thresh  = 8'($urandom_range(0, 255));
            run_frame(3, (k % 2 == 1) ? W + 2 : W, -1, 0, -1);
        end

        // Short vsync pulses to wrap frame_cnt.
        for (int k = 0; k < 250; k++) begin
            step(1'b1, '0, 1'b1, 1'b0, 1'b0);
            step(1'b1, '0, 1'b1, 1'b1, 1'b0);
        end
        check("frame_cnt_wrapped", 64'(frame_cnt < 8'd100), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_grad_filter.md
Name: vga_grad_filter

Overview:
- Parametrised, streaming per-pixel gradient filter on the VGA video path, between the frame source (camera/VGA controller) and the DAC outputs.
- Computes per-channel horizontal, vertical or combined absolute-difference edge maps. The vertical neighbour comes from an internal one-line buffer.
- All sync/blank signals are delayed to match the data latency, so video timing is preserved.

Parameters:
- WIDTH, 640: active pixels per line; sets line-buffer depth and x-counter range.
- HEIGHT, 480: active lines per frame; sets y-counter range.
- CW, 8: bits per colour channel.

Ports:
- VGA_CLK  in  1  pixel clock (25 MHz).
- reset_n  in  1  synchronous, active-low reset.
- iVGA_R/iVGA_G/iVGA_B  in  CW each  input colour.
- iVGA_HS, iVGA_VS, iVGA_SYNC_N, iVGA_BLANK_N  in  1 each  input timing.
- mode  in  2  0=pass, 1=horizontal diff, 2=vertical diff, 3=sum.
- chan_en  in  3  per-channel filter enable {R,G,B}; a 0 bit passes that channel through.
- thresh  in  CW  binarisation threshold (used only with the optional feature).
- oVGA_R/oVGA_G/oVGA_B  out  CW each  output colour.
- oVGA_HS, oVGA_VS, oVGA_SYNC_N, oVGA_BLANK_N  out  1 each  output timing.
- frame_cnt  out  8  frames completed (wrapping).

Behaviour:
- **Clock and reset.** Clock is VGA_CLK. reset_n is synchronous and active-low.
- **Reset values.** On reset_n=0 at a clock edge:
  - colour outputs = 0; oVGA_HS = 1; oVGA_VS = 1; oVGA_SYNC_N = 0; oVGA_BLANK_N = 0.
  - x and y counters = 0; frame_cnt = 0; mode_q = 0; chan_en_q = 0; row_valid = 0.
  - Line-buffer contents are don't-care.
- **Latency.** Fixed at 2 cycles for every signal, including HS/VS/SYNC_N/BLANK_N.
  - Stage 1 registers the input and reads the line buffer at address x.
  - Stage 2 computes the result and registers the outputs.
- **Counters.**
  - x increments on each input cycle with BLANK_N=1. It clears to 0 on each cycle with BLANK_N=0.
  - y increments on a falling edge of BLANK_N. It clears to 0 while VS=0.
  - x saturates at WIDTH-1; pixels beyond that are not written.
- **Line buffer.** WIDTH entries × 3·CW bits, read-before-write at address x on every active pixel. Each active pixel writes the current pixel at address x.
- **row_valid.** Cleared while VS=0 or on reset. Set at the first falling edge of BLANK_N after that.
  - When row_valid=0, the vertical neighbour equals the current pixel (vertical diff = 0).
- **Horizontal neighbour.** The previous active pixel on the same line. At x=0 it equals the current pixel (horizontal diff = 0).
- **Per-channel arithmetic** (unsigned, CW bits):
  - h = |p − left|; v = |p − up|.
  - mode 1 → h; mode 2 → v.
  - mode 3 → min(h+v, 2^CW−1), with the sum computed at CW+1 bits and saturated.
  - mode 0 → p.
- **Configuration latching.** mode and chan_en are latched into mode_q/chan_en_q only on cycles with iVGA_VS=0, so there is no mid-frame tearing. Changes during a frame take effect at the next vsync.
- **Blanking.** Colour outputs are forced to 0 whenever the delayed BLANK_N is 0, regardless of mode.
- **frame_cnt.** Increments on each rising edge of iVGA_VS (end of sync pulse). Wraps 255→0.
- **Reset mid-frame.** Outputs return to reset values on the next edge. After release, filtering resumes with row_valid=0 and x=0 until the next blank.
- **Simultaneous events.** Reset dominates. A VS=0 clear dominates the y increment.

Optional Feature:
- Macro: VGA_GRAD_FILTER_THRESH_EN.
- **Defined:** after the mode computation, each enabled channel in modes 1–3 is binarised. result ≥ thresh → 2^CW−1, else 0. Mode 0 and disabled channels are unaffected. Latency stays 2 cycles.
- **Undefined:** the thresh input is ignored and the raw difference/sum is output.

Test Plan:
- **Pass-through.** mode=0, chan_en=3'b111, 10×10 frame with R=x, G=y, B=x+y → output identical to input, shifted exactly 2 cycles; HS/VS/BLANK_N also shifted 2 cycles; colour outputs 0 during blank.
- **Horizontal diff.** mode=1 (latched during VS low), same image → R=0 at x=0 and 1 elsewhere; G=0 everywhere; B=0 at x=0 and 1 elsewhere.
- **Vertical diff.** mode=2 → R=0 everywhere; G=0 on row 0 and 1 on rows 1–9; B=0 on row 0 and 1 elsewhere. Change mode to 1 mid-frame → no change until after the next VS low.
- **Saturation and channel mask.** mode=3, chan_en=3'b100, checkerboard of R alternating 0/255 → R=255 interior (h+v saturated), R=0 at pixel (0,0); G and B pass through unchanged.
- **Reset mid-frame.** Assert reset_n=0 for 3 cycles at line 5 → during reset outputs read R/G/B=0, HS=1, VS=1, BLANK_N=0; frame_cnt=0; the first line after release shows vertical diff = 0.
- **Threshold (macro defined).** thresh=2, mode=1, R=x ramp ×3 → R=255 for x≥1, 0 at x=0. With the macro undefined → R=3 for x≥1.
